// File: rtl/vram_access_ctrl_pkg.sv
// Shared constants for the VRAM access controller: bus widths, FSM encodings, latched request control.
package vram_access_ctrl_pkg;

    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 16;
    localparam int VRAM_BYTE_W = 8;
    localparam int VRAM_LANE_W = 14;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

    typedef struct packed {
        logic       write;
        logic [1:0] wmask;
    } req_ctl_t;

    function automatic int max_cycles(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vram_access_ctrl_phase_timer.sv
// Loadable phase down-counter; done_o is high while the count is zero.
// Load takes priority; the count parks at zero instead of wrapping.
module vram_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vram_access_ctrl.sv
// Single-word VRAM SRAM sequencer: SETUP/STROBE/HOLD(/TURN) with registered pins, one request in flight.
// req_ready is low for the whole access; rsp_valid pulses in the first HOLD cycle.
module vram_access_ctrl
    import vram_access_ctrl_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 3,
    parameter int HOLD_CYCLES   = 1,
    parameter int TURN_CYCLES   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [VRAM_ADDR_W-1:0] req_addr,
    input  logic [VRAM_DATA_W-1:0] req_wdata,
    input  logic [1:0]             req_wmask,
    output logic                   rsp_valid,
    output logic [VRAM_DATA_W-1:0] rsp_rdata,
    output logic                   vrd_n,
    output logic                   vawr_n,
    output logic                   vbwr_n,
    output logic                   va14,
    output logic [VRAM_LANE_W-1:0] vaa,
    output logic [VRAM_LANE_W-1:0] vab,
    output logic                   lvl_vd_dir,
    output logic                   vd_tristate,
    output logic [VRAM_BYTE_W-1:0] vda_o,
    output logic [VRAM_BYTE_W-1:0] vdb_o,
    input  logic [VRAM_BYTE_W-1:0] vda_i,
    input  logic [VRAM_BYTE_W-1:0] vdb_i
);

    localparam int MAX_CYC = max_cycles(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TURN_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TURN   = CNT_W'(TURN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    req_ctl_t         ctl_q, ctl_d;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    logic                   req_ready_q, rsp_valid_q;
    logic [VRAM_DATA_W-1:0] rsp_rdata_q;
    logic                   vrd_n_q, vawr_n_q, vbwr_n_q;
    logic                   va14_q;
    logic [VRAM_LANE_W-1:0] vaa_q, vab_q;
    logic                   dir_q, tri_q;
    logic [VRAM_BYTE_W-1:0] vda_q, vdb_q;

    logic drive_d, strobe_d, rsp_valid_d;

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign ctl_d  = accept ? req_ctl_t'{write: req_write, wmask: req_wmask} : ctl_q;

    // Every transition reloads the timer with the entered state's length minus one.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d  = ctl_q.write ? ST_TURN : ST_IDLE;
                    tmr_load = 1'b1;
                    tmr_val  = ctl_q.write ? LD_TURN : '0;
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tmr_load = 1'b1;
            end
        endcase
    end

    // Pins are registered from the next state so they change on the state's entry edge.
    assign drive_d     = ctl_d.write &&
                         ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD));
    assign strobe_d    = (state_d == ST_STROBE);
    assign rsp_valid_d = (state_q == ST_STROBE) && tmr_done;

    vram_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctl_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            vrd_n_q     <= 1'b1;
            vawr_n_q    <= 1'b1;
            vbwr_n_q    <= 1'b1;
            va14_q      <= 1'b0;
            vaa_q       <= '0;
            vab_q       <= '0;
            dir_q       <= 1'b0;
            tri_q       <= 1'b1;
            vda_q       <= '0;
            vdb_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= rsp_valid_d;
            vrd_n_q     <= !(strobe_d && !ctl_d.write);
            vawr_n_q    <= !(strobe_d && ctl_d.write && ctl_d.wmask[0]);
            vbwr_n_q    <= !(strobe_d && ctl_d.write && ctl_d.wmask[1]);
            dir_q       <= drive_d;
            tri_q       <= !drive_d;
            if (accept) begin
                va14_q <= req_addr[VRAM_ADDR_W-1];
                vaa_q  <= req_addr[VRAM_LANE_W-1:0];
                vab_q  <= req_addr[VRAM_LANE_W-1:0];
                if (req_write) begin
                    vda_q <= req_wdata[VRAM_BYTE_W-1:0];
                    vdb_q <= req_wdata[VRAM_DATA_W-1:VRAM_BYTE_W];
                end
            end
            if (rsp_valid_d && !ctl_q.write) begin
                rsp_rdata_q <= {vdb_i, vda_i};
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign vrd_n       = vrd_n_q;
    assign vawr_n      = vawr_n_q;
    assign vbwr_n      = vbwr_n_q;
    assign va14        = va14_q;
    assign vaa         = vaa_q;
    assign vab         = vab_q;
    assign lvl_vd_dir  = dir_q;
    assign vd_tristate = tri_q;
    assign vda_o       = vda_q;
    assign vdb_o       = vdb_q;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Directed bench for vram_access_ctrl with a behavioural two-chip SRAM on the pins and a response scoreboard.
module tb_vram_access_ctrl;

    localparam int S = 1;
    localparam int W = 2;
    localparam int H = 1;
    localparam int T = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_wmask;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        vrd_n, vawr_n, vbwr_n, va14;
    logic [13:0] vaa, vab;
    logic        lvl_vd_dir, vd_tristate;
    logic [7:0]  vda_o, vdb_o, vda_i, vdb_i;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [7:0]  mem_a [0:32767];
    logic [7:0]  mem_b [0:32767];
    logic [7:0]  ref_a [0:32767];
    logic [7:0]  ref_b [0:32767];
    logic [15:0] sb_q [$];
    logic [15:0] exp_last;

    always #5 clock = ~clock;

    vram_access_ctrl #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(W),
        .HOLD_CYCLES  (H),
        .TURN_CYCLES  (T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .vrd_n      (vrd_n),
        .vawr_n     (vawr_n),
        .vbwr_n     (vbwr_n),
        .va14       (va14),
        .vaa        (vaa),
        .vab        (vab),
        .lvl_vd_dir (lvl_vd_dir),
        .vd_tristate(vd_tristate),
        .vda_o      (vda_o),
        .vdb_o      (vdb_o),
        .vda_i      (vda_i),
        .vdb_i      (vdb_i)
    );

    // SRAM model: asynchronous read, write while the strobe is low and the FPGA drives.
    assign vda_i = mem_a[{va14, vaa}];
    assign vdb_i = mem_b[{va14, vab}];

    always @(negedge clock) begin
        if (!vawr_n && !vd_tristate) mem_a[{va14, vaa}] = vda_o;
        if (!vbwr_n && !vd_tristate) mem_b[{va14, vab}] = vdb_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus-contention monitor and response scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (!vrd_n && (!vawr_n || !vbwr_n)) viol++;
            if (!vd_tristate && !vrd_n) viol++;
            if (!vd_tristate && !lvl_vd_dir) viol++;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic wr, input logic [14:0] addr, input logic [15:0] data,
                          input logic [1:0] mask, input string tag);
        int guard, k, wa_lo, wb_lo, rd_lo, tri_lo, rsp_k, last_tri;
        logic [31:0] pins1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~data;
        req_wmask = ~mask;
        if (wr) begin
            if (mask[0]) ref_a[addr] = data[7:0];
            if (mask[1]) ref_b[addr] = data[15:8];
        end else begin
            exp_last = {ref_b[addr], ref_a[addr]};
        end
        sb_q.push_back(exp_last);
        k = 0; wa_lo = 0; wb_lo = 0; rd_lo = 0; tri_lo = 0; rsp_k = 0; last_tri = 0;
        pins1 = '0;
        do begin
            @(negedge clock);
            k++;
            if (!req_ready) begin
                if (!vawr_n) wa_lo++;
                if (!vbwr_n) wb_lo++;
                if (!vrd_n) rd_lo++;
                if (!vd_tristate) tri_lo++;
                if (rsp_valid) rsp_k = k;
                if (k == 1) pins1 = {va14, vaa, vda_o, vdb_o, 1'b0};
                if (k == 1 && vab != vaa) pins1 = '1;
                last_tri = int'(vd_tristate);
            end
        end while (!req_ready && k < 40);
        check({tag, "_rsp_cycle"}, rsp_k, S + W + 1);
        if (wr) begin
            check({tag, "_occupancy"}, k - 1, S + W + H + T);
            check({tag, "_vawr_lo"}, wa_lo, mask[0] ? W : 0);
            check({tag, "_vbwr_lo"}, wb_lo, mask[1] ? W : 0);
            check({tag, "_tri_lo"}, tri_lo, S + W + H);
            check({tag, "_turn_tri"}, last_tri, 1);
            check({tag, "_pins"}, pins1, {addr[14], addr[13:0], data[7:0], data[15:8], 1'b0});
        end else begin
            check({tag, "_occupancy"}, k - 1, S + W + H);
            check({tag, "_vrd_lo"}, rd_lo, W);
            check({tag, "_tri_lo"}, tri_lo, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem_a[i] = 8'h00; mem_b[i] = 8'h00;
            ref_a[i] = 8'h00; ref_b[i] = 8'h00;
        end
        exp_last  = 16'h0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_strobes", {29'd0, vrd_n, vawr_n, vbwr_n}, 32'h7);
        check("rst_bus", {30'd0, vd_tristate, lvl_vd_dir}, 32'h2);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_addr", {17'd0, va14, vaa}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_req(1'b1, 15'h4123, 16'hB2A1, 2'b11, "wr_full");
        do_req(1'b0, 15'h4123, 16'h0000, 2'b00, "rd_full");
        do_req(1'b1, 15'h4123, 16'h5566, 2'b01, "wr_lo");
        do_req(1'b0, 15'h4123, 16'h0000, 2'b00, "rd_lo");
        do_req(1'b1, 15'h4123, 16'hFFFF, 2'b00, "wr_none");
        do_req(1'b0, 15'h4123, 16'h0000, 2'b00, "rd_none");
        do_req(1'b1, 15'h0200, 16'hCAFE, 2'b11, "wr_b2b");
        do_req(1'b0, 15'h0200, 16'h0000, 2'b00, "rd_b2b");

        // Abort a write in its STROBE phase; no response may follow.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h0055;
        req_wdata = 16'h1234;
        req_wmask = 2'b11;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_in_strobe", {30'd0, vawr_n, vbwr_n}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_strobes", {29'd0, vrd_n, vawr_n, vbwr_n}, 32'h7);
        check("abort_bus", {30'd0, vd_tristate, lvl_vd_dir}, 32'h2);
        check("abort_idle", {30'd0, req_ready, rsp_valid}, 32'h2);
        check("abort_rdata", {16'd0, rsp_rdata}, 32'd0);
        reset = 1'b0;
        exp_last = 16'h0;
        repeat (8) @(negedge clock);

        do_req(1'b0, 15'h4123, 16'h0000, 2'b00, "rd_recover");
        repeat (4) @(negedge clock);
        check("sb_empty", sb_q.size(), 0);
        check("bus_conflicts", viol, 0);
        check("rd_recover_value", {16'd0, rsp_rdata}, 32'h0000B266);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
